// File: rtl/aes_mixcol_engine.sv
// ============================================================================
// Module   : aes_mixcol_engine
// Purpose  : Iterative AES MixColumns / InvMixColumns engine for a full
//            128-bit state.  A block is accepted in IDLE, transformed
//            COLS_PER_CYCLE columns per cycle in BUSY, then held in DONE
//            until the consumer takes it.
// Ports    : clk_i, rst_ni         clock, async active-low reset
//            in_valid_i/in_ready_o input handshake
//            inv_i                 0 = MixColumns, 1 = InvMixColumns (latched)
//            state_i / state_o     128-bit state, column c at [127-32c -: 32],
//                                  row 0 in the MSB byte of each column
//            out_valid_o/out_ready_i output handshake
//            busy_o                high in BUSY and DONE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_mixcol_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         inv_i,
    input  logic [127:0] state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o,
    output logic         busy_o
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter advance; 4 columns per cycle wraps to 0, which is harmless
    // because the block completes in that single cycle.
    localparam logic [1:0] c_col_step = 2'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_fsm;
    logic [1:0]    r_cnt;
    logic [127:0]  r_state;
    logic          r_inv;

    // GF(2^8) doubling, reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the forward or inverse mixing matrix.  All
    // multiples come from a single xtime chain per byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m3 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m3[i] = x2[i] ^ a[i];
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (!inv) begin
            res[31:24] = x2[0] ^ m3[1] ^ a[2]  ^ a[3];
            res[23:16] = a[0]  ^ x2[1] ^ m3[2] ^ a[3];
            res[15:8]  = a[0]  ^ a[1]  ^ x2[2] ^ m3[3];
            res[7:0]   = m3[0] ^ a[1]  ^ a[2]  ^ x2[3];
        end else begin
            res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return res;
    endfunction

    // Per-lane column index, bit offset inside the state, and result.
    // Offset of column c is 32*(3-c), and 3-c equals ~c for a 2-bit c.
    logic [1:0]  w_idx [COLS_PER_CYCLE];
    logic [6:0]  w_pos [COLS_PER_CYCLE];
    logic [31:0] w_mix [COLS_PER_CYCLE];
    logic        w_last;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign w_idx[g] = r_cnt + 2'(g);
        assign w_pos[g] = {~w_idx[g], 5'b00000};
        assign w_mix[g] = mix_column(r_state[w_pos[g] +: 32], r_inv);
    end

    assign w_last  = (w_idx[COLS_PER_CYCLE-1] == 2'd3);
    assign state_o = r_state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fsm       <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_state     <= '0;
            r_inv       <= 1'b0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_state    <= state_i;
                        r_inv      <= inv_i;
                        r_cnt      <= 2'd0;
                        r_fsm      <= ST_BUSY;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        r_state[w_pos[i] +: 32] <= w_mix[i];
                    end
                    r_cnt <= r_cnt + c_col_step;
                    if (w_last) begin
                        r_fsm       <= ST_DONE;
                        out_valid_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        r_fsm       <= ST_IDLE;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    r_fsm       <= ST_IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
